pc_next_sequencer: RTL
======================

# pc_next_sequencer

Program-counter register and next-address sequencer for the single-cycle datapath. It sits directly downstream of the jump-field left-shift stage. It consumes the 28-bit shifted jump field, the shifted branch offset and the register jump target, and produces the fetch address each cycle. It also handles fetch stalls, holding a redirect that arrives during a stall, and traps misaligned targets.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset (word aligned)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- jump_target_low  in  28  shifted jump field, instr[25:0] with 2'b00 appended
- branch_offset_sl2  in  32  sign-extended immediate shifted left 2
- jr_target  in  32  register-sourced jump address (rs)
- branch_taken  in  1  conditional branch resolved taken
- jump  in  1  J/JAL in decode
- jump_reg  in  1  JR in decode
- stall  in  1  hold fetch (hazard or instruction memory not ready)
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4 (combinational from pc)
- redirect_pending  out  1  a redirect is latched and waiting for the stall to end
- misaligned  out  1  sticky fault: a redirect target had bits [1:0] != 0

## Operation
- pc_plus4 = pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect request = jump_reg | jump | branch_taken. Priority is jump_reg > jump > branch_taken.
- Redirect targets:
  - jump_reg: jr_target
  - jump: {pc_plus4[31:28], jump_target_low}
  - branch: pc_plus4 + branch_offset_sl2, modulo 2^32, overflow ignored
- Internal register pend_target (32 bits) holds a redirect captured during a stall.
- States:
  - RUN:
    - redirect and target misaligned: go to FAULT; pc holds; misaligned <= 1. The fault check takes precedence over stall.
    - redirect and stall: go to PEND; pend_target <= selected target; pc holds.
    - redirect and !stall: pc <= target.
    - no redirect and stall: pc holds.
    - otherwise: pc <= pc_plus4.
  - PEND:
    - stall: pc holds. Redirect inputs are ignored; the first capture wins.
    - !stall: pc <= pend_target; go to RUN. Redirect inputs that cycle are ignored.
  - FAULT:
    - pc frozen; misaligned = 1; all inputs ignored. Only reset exits.
- redirect_pending = 1 exactly when state is PEND.
- Reset, at any time including mid-PEND or in FAULT:
  - pc = RESET_PC, state = RUN, pend_target = 0, misaligned = 0, redirect_pending = 0.
  - pc_plus4 = RESET_PC + 4.

## Timing
- All state changes on the rising clk edge. Reset acts immediately on assertion, independent of clk.
- Redirect latency: target appears on pc one cycle after the request edge when not stalled. With a stall, it appears one cycle after the first cycle with stall = 0.
- Sequential latency: pc advances by 4 every unstalled cycle.
- No combinational path from any input to pc, redirect_pending or misaligned.
- pc_plus4 depends on pc only.
- A request and the release of a stall in the same cycle (in RUN) is treated as an unstalled redirect.

## Test plan
- Reset release, 3 unstalled cycles, no redirects -> pc = 0x0, 0x4, 0x8, 0xC. misaligned = 0, redirect_pending = 0.
- pc = 0x1000_0040, jump = 1, jump_target_low = 28'h000_0100 -> next pc = 0x1000_0100.
- pc = 0x0000_0020, branch_taken = 1, branch_offset_sl2 = 0xFFFF_FFF0 -> next pc = 0x0000_0014.
- Same cycle jump_reg = 1 (jr_target = 0x0000_4000), jump = 1, branch_taken = 1 -> next pc = 0x0000_4000.
- Stall with pending redirect:
  - Stimulus: stall = 1 for 3 cycles with jump_reg = 1, jr_target = 0x0000_0200. In cycle 2, change jr_target to 0x0000_0300.
  - Required: pc held; redirect_pending = 1 for those 3 cycles. On the first stall = 0 edge, pc = 0x0000_0200 and redirect_pending = 0.
- Misaligned target and wrap:
  - Stimulus: jump_reg = 1, jr_target = 0x0000_0102.
  - Required: misaligned = 1, pc frozen through 5 further cycles and subsequent valid jumps. Asserting reset mid-cycle gives pc = RESET_PC and misaligned = 0 without a clock edge.
  - Separately: pc = 0xFFFF_FFFC unstalled -> next pc = 0x0000_0000.

Source files
------------

// File: rtl/pc_next_sequencer.sv
// pc_next_sequencer: program-counter register and next-address sequencer.
// Selects the next fetch address from sequential, branch, jump and
// register-jump sources. It holds a redirect that arrives during a fetch
// stall and freezes on a misaligned redirect target.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   jump_target_low    28-bit shifted jump field (instr[25:0], 2'b00)
//   branch_offset_sl2  sign-extended branch immediate shifted left 2
//   jr_target          register-sourced jump address
//   branch_taken       conditional branch resolved taken
//   jump, jump_reg     J/JAL and JR in decode
//   stall              hold fetch
//   pc                 current fetch address (registered)
//   pc_plus4           pc + 4 (combinational from pc only)
//   redirect_pending   a captured redirect waits for the stall to end
//   misaligned         sticky fault on a redirect target with bits [1:0] != 0
module pc_next_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [27:0] jump_target_low,
  input  logic [31:0] branch_offset_sl2,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        redirect_pending,
  output logic        misaligned
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned JLEN = 28;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pend_target, pend_target_next;
  logic [XLEN-1:0] pc_next;
  logic            misaligned_next;
  logic            pending_next;

  logic            redirect;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] target;
  logic            target_misaligned;

  // Sequential address; wraps naturally modulo 2^32.
  assign pc_plus4 = pc + XLEN'(4);

  assign branch_target = pc_plus4 + branch_offset_sl2;
  assign redirect      = jump_reg | jump | branch_taken;

  // Target select: jump_reg over jump over branch.
  always_comb begin
    target = branch_target;
    if (jump_reg) begin
      target = jr_target;
    end else if (jump) begin
      target = {pc_plus4[XLEN-1:JLEN], jump_target_low};
    end
  end

  assign target_misaligned = |target[1:0];

  // Next-state and next-register logic.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pend_target_next = pend_target;
    misaligned_next  = misaligned;

    unique case (state)
      RUN: begin
        // Fault check wins over stall so a bad target is never parked.
        if (redirect && target_misaligned) begin
          state_next      = FAULT;
          misaligned_next = 1'b1;
        end else if (redirect && stall) begin
          state_next       = PEND;
          pend_target_next = target;
        end else if (redirect) begin
          pc_next = target;
        end else if (!stall) begin
          pc_next = pc_plus4;
        end
      end
      PEND: begin
        // First captured redirect wins; new requests are dropped.
        if (!stall) begin
          pc_next    = pend_target;
          state_next = RUN;
        end
      end
      FAULT: begin
        misaligned_next = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase

    pending_next = (state_next == PEND);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= RUN;
      pc               <= RESET_PC;
      pend_target      <= '0;
      misaligned       <= 1'b0;
      redirect_pending <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      pend_target      <= pend_target_next;
      misaligned       <= misaligned_next;
      redirect_pending <= pending_next;
    end
  end

endmodule
